cbm_arb2: RTL
=============

CBM_ARB2 -- requirements
Module: cbm_arb2

Interface
REQ-001 Parameter: ADDR_W, 32, requester/bus address width.
REQ-002 Parameter: DATA_W, 32, requester/bus data width.
REQ-003 Port: bus1_HCLK  in  1  sole clock, all state on rising edge.
REQ-004 Port: bus1_HRESETn  in  1  asynchronous active-low reset.
REQ-005 Port: rq{0,1}_req  in  1  requester command request, held until its ack.
REQ-006 Port: rq{0,1}_wr  in  1  1=write, 0=read.
REQ-007 Port: rq{0,1}_addr  in  ADDR_W  transfer address.
REQ-008 Port: rq{0,1}_wdata  in  DATA_W  write data.
REQ-009 Port: rq{0,1}_ack  out  1  one-cycle completion pulse.
REQ-010 Port: rq{0,1}_err  out  1  one-cycle error pulse, coincident with ack.
REQ-011 Port: rdata  out  DATA_W  captured read data, valid with any ack.
REQ-012 Ports to CybusM master: CBM_read_req, CBM_write_req (out 1), CBM_burst (out 3), CBM_addr (out ADDR_W), CBM_length (out 11), CBM_size (out 3), CBM_lock (out 1), CBM_write_data (out DATA_W), CBM_read_data (in DATA_W), CBM_command_busy, CBM_data_ready, CBM_error (in 1).

Function
REQ-013 FSM states IDLE=0, ISSUE=1, DONE=2; encoding 3 unused -> IDLE next cycle.
REQ-014 IDLE: if any rq_req=1, select winner, latch its wr/addr/wdata, -> ISSUE; else stay.
REQ-015 Arbitration round-robin: both requesting -> grant the one not granted last; single requester -> granted regardless of pointer.
REQ-016 Pointer updates only on DONE exit; reset value: rq1 last granted (rq0 wins first tie).
REQ-017 ISSUE: drive CBM_write_req=wr, CBM_read_req=~wr, burst=3'h0, length=11'h001, size=3'h2, lock=0, addr=latched addr, write_data=latched wdata (write only, else 0).
REQ-018 ISSUE exit when CBM_command_busy=0 and CBM_data_ready=1 in same cycle; capture CBM_read_data into rdata (reads only; writes leave rdata unchanged) -> DONE.
REQ-019 Outside ISSUE every CBM output SHALL be 0.
REQ-020 DONE: assert rq_ack of granted requester for exactly one cycle -> IDLE.
REQ-021 rq_req sampled only in IDLE; requester deasserts req in cycle after ack, else re-arbitrated as new request.
REQ-022 Minimum latency req rise -> ack = 3 cycles (IDLE, ISSUE, DONE); ISSUE stalls indefinitely while busy=1 or data_ready=0.
REQ-023 Request changes while ISSUE/DONE SHALL NOT affect in-flight transfer.

Reset
REQ-024 Reset SHALL force IDLE, pointer per REQ-016, rdata=0, all acks/errs=0, all CBM outputs 0.
REQ-025 Reset mid-ISSUE SHALL abort transfer without ack; requests resampled after release.

Configuration
REQ-026 Macro CBM_ARB2_ERROR_EN defined: in ISSUE, CBM_error=1 -> DONE, rq_err and rq_ack pulse together, rdata unchanged; error has priority over data_ready.
REQ-027 Macro undefined: CBM_error ignored, rq_err tied 0, ports unchanged.

Structure
REQ-028 Shared package holds FSM state typedef/encodings and CybusM constants (BURST_SINGLE=3'h0, SIZE_WORD=3'h2, LEN_ONE=11'h001).
REQ-029 Sub-module cbm_rr_arb2: combinational 2-way round-robin grant from req vector and last-grant pointer.

Verification
REQ-030 rq0 write addr 0x10000100 data 0xA5, busy=0, ready=1 -> write_req=1 one cycle with those values, rq0_ack at cycle 3.
REQ-031 rq0 and rq1 both request continuously -> grants alternate rq0, rq1, rq0, rq1 over 4 transfers.
REQ-032 rq1 read, busy=1 for 5 cycles then ready=1 with read_data 0x12345678 -> ISSUE held 6 cycles, rdata=0x12345678 at rq1_ack.
REQ-033 bus1_HRESETn low during ISSUE -> all CBM outputs 0 next edge, no ack; rq0 retained -> re-issued after release.
REQ-034 With CBM_ARB2_ERROR_EN, CBM_error=1 in ISSUE -> rq_err=rq_ack=1 one cycle; without macro -> transfer waits for ready, rq_err stays 0.

Source files
------------

// File: rtl/cbm_arb2_pkg.sv
// -----------------------------------------------------------------------------
// cbm_arb2_pkg
// Shared definitions for the two-requester CybusM arbiter:
//   - FSM state type and encodings (IDLE=0, ISSUE=1, DONE=2; 3 is unused)
//   - CybusM single-beat command constants
//   - helper that maps a one-bit grant index to a one-hot grant vector
// -----------------------------------------------------------------------------
package cbm_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    // Every command is a single, word-sized, unlocked beat.
    localparam logic [2:0]  BURST_SINGLE = 3'h0;
    localparam logic [2:0]  SIZE_WORD    = 3'h2;
    localparam logic [10:0] LEN_ONE      = 11'h001;

    function automatic logic [1:0] idx_to_onehot(input logic valid, input logic idx);
        idx_to_onehot = valid ? (idx ? 2'b10 : 2'b01) : 2'b00;
    endfunction

endpackage

// File: rtl/cbm_rr_arb2.sv
// -----------------------------------------------------------------------------
// cbm_rr_arb2
// Combinational two-way round-robin arbiter.
//   req_i[1:0]  in   request vector (bit n = requester n)
//   last_i      in   index of the requester granted most recently
//   valid_o     out  at least one request present
//   gnt_idx_o   out  index of the winning requester (meaningful when valid_o)
//   gnt_o[1:0]  out  one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module cbm_rr_arb2
    import cbm_arb2_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       gnt_idx_o,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_idx_o = 1'b0;
        unique case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            // Tie: the requester that was not served last time wins.
            2'b11:   gnt_idx_o = ~last_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

    assign valid_o = |req_i;
    assign gnt_o   = idx_to_onehot(valid_o, gnt_idx_o);

endmodule

// File: rtl/cbm_arb2.sv
// -----------------------------------------------------------------------------
// cbm_arb2
// Arbitrates two simple command requesters onto one CybusM master port.
// One single-beat transfer is in flight at a time: IDLE picks a winner and
// latches its command, ISSUE presents it to CybusM until the master accepts
// and completes it, DONE pulses the winner's ack for one cycle.
//
// Ports
//   bus1_HCLK, bus1_HRESETn        clock, asynchronous active-low reset
//   rq{0,1}_req/_wr/_addr/_wdata   requester command (req held until ack)
//   rq{0,1}_ack/_err               one-cycle completion / error pulses
//   rdata                          last captured read data
//   CBM_*                          CybusM master command/data interface
//
// Build option
//   CBM_ARB2_ERROR_EN  when defined, CBM_error during ISSUE ends the transfer
//                      with rq_err and rq_ack pulsing together. When not
//                      defined, CBM_error is ignored and rq_err is tied low.
// -----------------------------------------------------------------------------
module cbm_arb2
    import cbm_arb2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              bus1_HCLK,
    input  logic              bus1_HRESETn,

    input  logic              rq0_req,
    input  logic              rq0_wr,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic              rq0_err,

    input  logic              rq1_req,
    input  logic              rq1_wr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic              rq1_err,

    output logic [DATA_W-1:0] rdata,

    output logic              CBM_read_req,
    output logic              CBM_write_req,
    output logic [2:0]        CBM_burst,
    output logic [ADDR_W-1:0] CBM_addr,
    output logic [10:0]       CBM_length,
    output logic [2:0]        CBM_size,
    output logic              CBM_lock,
    output logic [DATA_W-1:0] CBM_write_data,
    input  logic [DATA_W-1:0] CBM_read_data,
    input  logic              CBM_command_busy,
    input  logic              CBM_data_ready,
    input  logic              CBM_error
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;     // index of last granted requester
    logic              gnt_q, gnt_d;       // index of requester in flight
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              arb_valid;
    logic              arb_idx;
    logic [1:0]        arb_gnt;
    logic              err_hit;
    logic              in_issue;
    logic              in_done;

    cbm_rr_arb2 u_rr (
        .req_i     ({rq1_req, rq0_req}),
        .last_i    (last_q),
        .valid_o   (arb_valid),
        .gnt_idx_o (arb_idx),
        .gnt_o     (arb_gnt)
    );

`ifdef CBM_ARB2_ERROR_EN
    assign err_hit = CBM_error;
`else
    logic unused_cbm_error;
    assign unused_cbm_error = CBM_error;
    assign err_hit          = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Next-state and transfer bookkeeping
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    wr_d    = arb_gnt[1] ? rq1_wr    : rq0_wr;
                    addr_d  = arb_gnt[1] ? rq1_addr  : rq0_addr;
                    wdata_d = arb_gnt[1] ? rq1_wdata : rq0_wdata;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // An error response wins over a simultaneous data_ready and
                // leaves rdata untouched.
                if (err_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!CBM_command_busy && CBM_data_ready) begin
                    if (!wr_q) begin
                        rdata_d = CBM_read_data;
                    end
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // The round-robin pointer only moves once a transfer retires.
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control and read-data registers
    // ---------------------------------------------------------------------
    always_ff @(posedge bus1_HCLK or negedge bus1_HRESETn) begin
        if (!bus1_HRESETn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;       // rq0 wins the first tie after reset
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latched command payload; only visible on CBM while in ISSUE, so it
    // needs no reset.
    always_ff @(posedge bus1_HCLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // ---------------------------------------------------------------------
    // Outputs, decoded from state so everything is zero outside ISSUE
    // ---------------------------------------------------------------------
    assign in_issue = (state_q == ST_ISSUE);
    assign in_done  = (state_q == ST_DONE);

    assign CBM_write_req  = in_issue &  wr_q;
    assign CBM_read_req   = in_issue & ~wr_q;
    assign CBM_burst      = in_issue ? BURST_SINGLE : 3'h0;
    assign CBM_length     = in_issue ? LEN_ONE      : 11'h000;
    assign CBM_size       = in_issue ? SIZE_WORD    : 3'h0;
    assign CBM_lock       = 1'b0;
    assign CBM_addr       = in_issue ? addr_q : '0;
    assign CBM_write_data = (in_issue && wr_q) ? wdata_q : '0;

    assign rq0_ack = in_done & ~gnt_q;
    assign rq1_ack = in_done &  gnt_q;

`ifdef CBM_ARB2_ERROR_EN
    assign rq0_err = rq0_ack & err_q;
    assign rq1_err = rq1_ack & err_q;
`else
    logic unused_err_q;
    assign unused_err_q = err_q;
    assign rq0_err      = 1'b0;
    assign rq1_err      = 1'b0;
`endif

    assign rdata = rdata_q;

endmodule
